// File: rtl/bilbo_pkg.sv
// Shared types for the BILBO BIST sequencer: BILBO mode encoding,
// sequencer states, default widths and state-to-mode decode helpers.
package bilbo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_PRPG   = 2'b10,
      MODE_MISR   = 2'b11
   } bilbo_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SEED,
      ST_RUN,
      ST_UNLOAD,
      ST_CHECK,
      ST_DONE
   } bist_state_e;

   function automatic logic is_busy(bist_state_e s);
      return (s == ST_CLEAR) || (s == ST_SEED) ||
             (s == ST_RUN) || (s == ST_UNLOAD) ||
             (s == ST_CHECK);
   endfunction

   function automatic bilbo_mode_e gen_mode_of(bist_state_e s);
      case (s)
         ST_SEED: return MODE_SCAN;
         ST_RUN:  return MODE_PRPG;
         default: return MODE_NORMAL;
      endcase
   endfunction

   function automatic bilbo_mode_e cmp_mode_of(bist_state_e s);
      case (s)
         ST_RUN:    return MODE_MISR;
         ST_UNLOAD: return MODE_SCAN;
         default:   return MODE_NORMAL;
      endcase
   endfunction

endpackage

// File: rtl/bist_shift_cnt.sv
// Loadable down-counter with zero/one flags; saturates at zero.
// Ports: clk, rst (async high), i_load/i_val, i_dec, o_zero, o_one.
module bist_shift_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic         o_zero,
   output logic         o_one
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
   assign o_one  = (r_cnt == W'(1));

endmodule

// File: rtl/bilbo_bist_ctrl.sv
// BIST sequencer driving a generator/compactor BILBO pair:
// clear, seed scan, PRPG/MISR run, signature unload, compare.
// Ports: clk, rst (async high), start, num_patterns, seed, golden,
//   gen_mode, gen_si, cmp_mode, cmp_clr, cmp_so, busy, done, pass,
//   signature. Macro BILBO_BIST_ABORT_EN adds input abort.
module bilbo_bist_ctrl
   import bilbo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef BILBO_BIST_ABORT_EN
   input  logic             abort,
`endif
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] golden,
   output logic [1:0]       gen_mode,
   output logic             gen_si,
   output logic [1:0]       cmp_mode,
   output logic             cmp_clr,
   input  logic             cmp_so,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int BIT_W = $clog2(WIDTH + 1);

   bist_state_e r_state;
   bist_state_e w_nxt;

   bilbo_mode_e r_gen_mode;
   bilbo_mode_e r_cmp_mode;
   logic        r_cmp_clr;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;

   logic [WIDTH-1:0] r_seed_sh;
   logic [WIDTH-1:0] r_golden;
   logic [WIDTH-1:0] r_sig;

   logic w_accept;
   logic w_abort;
   logic w_bit_load;
   logic w_bit_dec;
   logic w_bit_zero;
   logic w_bit_one;
   logic w_pat_dec;
   logic w_pat_zero;
   logic w_pat_one;

`ifdef BILBO_BIST_ABORT_EN
   assign w_abort = abort & is_busy(r_state);
`else
   assign w_abort = 1'b0;
`endif

   bist_shift_cnt #(.W(BIT_W)) u_bit_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_bit_load),
      .i_val  (BIT_W'(WIDTH)),
      .i_dec  (w_bit_dec),
      .o_zero (w_bit_zero),
      .o_one  (w_bit_one)
   );

   // Pattern count is captured straight from the port on start.
   bist_shift_cnt #(.W(CNT_W)) u_pat_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_val  (num_patterns),
      .i_dec  (w_pat_dec),
      .o_zero (w_pat_zero),
      .o_one  (w_pat_one)
   );

   always_comb begin
      w_nxt      = r_state;
      w_accept   = 1'b0;
      w_bit_load = 1'b0;
      w_bit_dec  = 1'b0;
      w_pat_dec  = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_nxt    = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            w_nxt      = ST_SEED;
            w_bit_load = 1'b1;
         end
         ST_SEED: begin
            w_bit_dec = 1'b1;
            if (w_bit_one || w_bit_zero) begin
               if (w_pat_zero) begin
                  w_nxt      = ST_UNLOAD;
                  w_bit_load = 1'b1;
               end else begin
                  w_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            w_pat_dec = 1'b1;
            if (w_pat_one || w_pat_zero) begin
               w_nxt      = ST_UNLOAD;
               w_bit_load = 1'b1;
            end
         end
         ST_UNLOAD: begin
            w_bit_dec = 1'b1;
            if (w_bit_one || w_bit_zero) begin
               w_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_nxt = ST_DONE;
         end
         default: begin
            w_nxt = ST_IDLE;
         end
      endcase
      if (w_abort) begin
         w_nxt = ST_DONE;
      end
   end

   // Outputs are registered from the next state so the BILBOs see the
   // new mode on the first edge inside each state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_gen_mode <= MODE_NORMAL;
         r_cmp_mode <= MODE_NORMAL;
         r_cmp_clr  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_seed_sh  <= '0;
         r_golden   <= '0;
         r_sig      <= '0;
      end else begin
         r_state    <= w_nxt;
         r_gen_mode <= gen_mode_of(w_nxt);
         r_cmp_mode <= cmp_mode_of(w_nxt);
         r_cmp_clr  <= (w_nxt == ST_CLEAR);
         r_busy     <= is_busy(w_nxt);
         r_done     <= (w_nxt == ST_DONE) &&
                       (r_state != ST_DONE);
         if (w_accept) begin
            r_seed_sh <= seed;
            r_golden  <= golden;
            r_pass    <= 1'b0;
            r_sig     <= '0;
         end
         if (r_state == ST_SEED) begin
            r_seed_sh <= r_seed_sh >> 1;
         end
         if (r_state == ST_UNLOAD) begin
            r_sig <= {r_sig[WIDTH-2:0], cmp_so};
         end
         if ((r_state == ST_CHECK) && !w_abort) begin
            r_pass <= (r_sig == r_golden);
         end
      end
   end

   assign gen_mode  = r_gen_mode;
   assign cmp_mode  = r_cmp_mode;
   assign cmp_clr   = r_cmp_clr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = r_sig;
   // LSB of the seed shifter is the bit for the current SEED cycle.
   assign gen_si    = (r_state == ST_SEED) & r_seed_sh[0];

endmodule

// File: doc/bilbo_bist_ctrl.md
# bilbo_bist_ctrl

Built-in self-test sequencer for a pair of BILBO registers around a combinational block under test. On `start` it clears the compactor BILBO and scans a seed into the generator BILBO. It then runs the generator as a PRPG and the compactor as a MISR for a programmed number of patterns, scans the signature out, and compares it against a golden value. It sits between the chip-level test control (pins or register bank) and the BILBO mode/scan pins.

## Interface
Parameters:
- `WIDTH`, 8: BILBO register width; length of seed and signature scans.
- `CNT_W`, 16: width of the pattern counter.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a BIST run; honoured only in IDLE or DONE.
- `num_patterns`  in  CNT_W: PRPG/MISR cycles; sampled when `start` is accepted.
- `seed`  in  WIDTH: generator seed; sampled when `start` is accepted.
- `golden`  in  WIDTH: expected signature; sampled when `start` is accepted.
- `gen_mode`  out  2: generator BILBO mode.
- `gen_si`  out  1: generator scan-in.
- `cmp_mode`  out  2: compactor BILBO mode.
- `cmp_clr`  out  1: one-cycle synchronous clear of the compactor.
- `cmp_so`  in  1: compactor scan-out (MSB of register).
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle pulse on completion.
- `pass`  out  1: signature == golden; valid from `done` until the next accepted `start`.
- `signature`  out  WIDTH: captured signature; held with `pass`.

## Operation
- Mode encoding: NORMAL=00, SCAN=01, PRPG=10, MISR=11.
- Reset values: all outputs 0; both modes NORMAL; state IDLE.
- IDLE: both modes NORMAL. On `start`, latch inputs, clear `pass`/`signature`, go to CLEAR.
- CLEAR (1 cycle): `cmp_clr`=1, `busy`=1. Next state is SEED.
- SEED (WIDTH cycles): `gen_mode`=SCAN; `gen_si` = seed bit k on the k-th cycle, LSB first. Next state is RUN, or UNLOAD if `num_patterns`==0.
- RUN (`num_patterns` cycles): `gen_mode`=PRPG, `cmp_mode`=MISR. A down-counter loads `num_patterns`; exit when it reaches 1. No wrap; the maximum is 2^CNT_W−1 cycles.
- UNLOAD (WIDTH cycles): `cmp_mode`=SCAN, `gen_mode`=NORMAL. Sample `cmp_so` each cycle into the shift register: `signature <= {signature[WIDTH-2:0], cmp_so}`, so the first bit out lands in the MSB.
- CHECK (1 cycle): `pass <= (signature == golden)`.
- DONE: `done`=1 for the entry cycle only; `busy`=0; modes NORMAL; remain in DONE until `start`.
- `start` while busy is ignored.
- Async `rst` mid-run returns to IDLE immediately; `pass` and `signature` clear.

## Timing
- Accepted `start` at edge t: `busy`=1 and `cmp_clr`=1 during cycle t+1.
- First `gen_si` bit during cycle t+2.
- `done` asserts at cycle t+1+1+WIDTH+N+WIDTH+1 (N = `num_patterns`).
- Example: WIDTH=8, N=0 gives `done` 19 cycles after `start`.
- Mode outputs are registered and change only at state transitions. BILBO registers therefore see the new mode on the first clock edge inside the state.
- `cmp_so` is sampled at the end of each UNLOAD cycle.

## Configuration
- `BILBO_BIST_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in any busy state forces DONE next cycle with `pass`=0, `done` pulsed, and modes NORMAL.
  - `abort` in IDLE or DONE is ignored.
  - If `abort` and `start` are both asserted in IDLE, `start` wins.
- Undefined: no `abort` port; runs always complete.

## Structure
- Package `bilbo_pkg`:
  - `bilbo_mode_e` (NORMAL/SCAN/PRPG/MISR, 2-bit).
  - `bist_state_e` (IDLE, CLEAR, SEED, RUN, UNLOAD, CHECK, DONE).
  - Default widths.
- Sub-module `bist_shift_cnt`: a loadable down-counter with zero/one flags. Instantiate it twice, once for the bit index in SEED/UNLOAD and once for the pattern count in RUN.

## Test plan
- Reset mid-SEED:
  - Stimulus: assert `rst` during SEED.
  - Required: all outputs 0 asynchronously, state IDLE; the next `start` runs normally.
- Seed scan:
  - Stimulus: WIDTH=8, seed=0xA5, N=0.
  - Required: `gen_si` sequence 1,0,1,0,0,1,0,1 during cycles t+2..t+9, then UNLOAD.
  - Required: `done` at t+19.
- Signature capture:
  - Stimulus: N=4 with a model BILBO pair; `cmp_so` stream 1,1,0,0,1,0,1,0 and golden=0xCA.
  - Required: `signature`=0xCA, `pass`=1, `done` at t+23.
- Mismatch:
  - Stimulus: same run with golden=0xCB.
  - Required: `pass`=0, `signature`=0xCA.
- Restart handling:
  - Stimulus: `start` pulsed during RUN.
  - Required: ignored, and cycle counts are unchanged.
  - Stimulus: `start` in DONE.
  - Required: `pass` clears and a new run begins.
- Abort (`BILBO_BIST_ABORT_EN`):
  - Stimulus: `abort` during RUN, N=1000.
  - Required: `done` next cycle, `pass`=0, modes NORMAL.
